// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a downstream UART transmitter.
// Bytes are queued in a DEPTH x 8 memory and launched one at a time with a
// single-cycle tx_start strobe, paced by the transmitter's tx_busy handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic [7:0]    tx_byte,
  output logic          tx_start,
  input  logic          tx_busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] GUARD  = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic          wr_ok;
  logic          pop;
  logic [AW:0]   count_next;

  // Accept/pop decisions and the resulting occupancy.
  // WAIT releasing with data pending launches directly, as IDLE would on the
  // same edge; this keeps back-to-back launches exactly 3 cycles apart.
  always_comb begin
    wr_ok      = wr_en && !full;
    pop        = ((state == IDLE) || (state == WAIT)) && !empty && !tx_busy;
    count_next = count;
    if (wr_ok && !pop)
      count_next = count + CNT_ONE;
    else if (pop && !wr_ok)
      count_next = count - CNT_ONE;
  end

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_MAX);
      if (wr_en && full)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  // Drain FSM: launch a byte, hold off one guard cycle, then wait for tx_busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_byte  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE, WAIT: begin
          if (pop) begin
            tx_byte  <= mem[rd_ptr];
            tx_start <= 1'b1;
            state    <= LAUNCH;
          end else if (!tx_busy) begin
            state <= IDLE;
          end
        end
        LAUNCH:  state <= GUARD;
        GUARD:   state <= WAIT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus a randomized phase, checked every
// cycle against a queue-based model of the FIFO and launch pacing rules.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          clr_overflow;
  logic [7:0]    tx_byte;
  logic          tx_start;
  logic          tx_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow), .tx_byte(tx_byte), .tx_start(tx_start),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue, a sticky overflow bit and the rule that a
  // launch needs stored data, tx_busy low and 3 edges since the last launch.
  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_start;
  logic [7:0] m_byte;
  int         last_launch = -100;
  int         edge_i = 0;
  int         m_pre;
  bit         m_pop;
  bit         mvalid = 0;

  always @(posedge clk) begin
    edge_i++;
    if (!rst_n) begin
      mq.delete();
      m_ovf       = 1'b0;
      m_start     = 1'b0;
      m_byte      = 8'h00;
      last_launch = -100;
      mvalid      = 1;
    end else begin
      m_pre = mq.size();
      m_pop = (m_pre > 0) && (tx_busy == 1'b0) && (edge_i - last_launch >= 3);
      if (m_pop) begin
        m_byte      = mq.pop_front();
        m_start     = 1'b1;
        last_launch = edge_i;
      end else begin
        m_start = 1'b0;
      end
      if (wr_en) begin
        if (m_pre == DEPTH) m_ovf = 1'b1;
        else mq.push_back(wr_data);
      end
      if (!(wr_en && m_pre == DEPTH) && clr_overflow)
        m_ovf = 1'b0;
    end
    #1;
    if (mvalid) begin
      check("count",    32'(count),    32'(mq.size()));
      check("empty",    32'(empty),    32'(mq.size() == 0));
      check("full",     32'(full),     32'(mq.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("tx_start", 32'(tx_start), 32'(m_start));
      check("tx_byte",  32'(tx_byte),  32'(m_byte));
    end
  end

  // Stimulus side: busy generator modes 0=forced, 1=10-cycle transmitter, 2=random.
  int         mode;
  logic       force_busy;
  int         bcnt;
  int         cyc;
  logic [7:0] lq[$];
  int         lt[$];

  task automatic nxt();
    @(negedge clk);
    cyc++;
    if (tx_start === 1'b1) begin
      lq.push_back(tx_byte);
      lt.push_back(cyc);
    end
    case (mode)
      0: tx_busy = force_busy;
      1: begin
        if (tx_start === 1'b1) check("start_while_busy", 32'(tx_busy), 32'h0);
        tx_busy = (bcnt > 0);
        if (bcnt > 0) bcnt--;
        if (tx_start === 1'b1) bcnt = 10;
      end
      default: tx_busy = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_empty(input int maxc, input string name);
    int n;
    n = 0;
    wr_en = 1'b0;
    while (empty !== 1'b1 && n < maxc) begin
      nxt();
      n++;
    end
    check(name, 32'(n < maxc), 32'h1);
    repeat (4) nxt();
  endtask

  logic [7:0] hello [5];
  int n;
  int sent;

  initial begin
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
    tx_busy = 1'b0; mode = 0; force_busy = 1'b0; bcnt = 0; cyc = 0;
    nxt(); nxt();
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full",  32'(full), 32'h0);
    check("rst_ovf",   32'(overflow), 32'h0);
    check("rst_start", 32'(tx_start), 32'h0);
    check("rst_byte",  32'(tx_byte), 32'h0);
    rst_n = 1'b1;
    nxt();

    // single byte
    wr_en = 1'b1; wr_data = 8'h41; nxt(); wr_en = 1'b0;
    check("single_cnt1", 32'(count), 32'h1);
    check("single_empty0", 32'(empty), 32'h0);
    check("single_start_early", 32'(tx_start), 32'h0);
    nxt();
    check("single_start", 32'(tx_start), 32'h1);
    check("single_byte", 32'(tx_byte), 32'h41);
    check("single_cnt0", 32'(count), 32'h0);
    check("single_empty1", 32'(empty), 32'h1);
    nxt();
    check("single_start_1cyc", 32'(tx_start), 32'h0);
    check("single_hold", 32'(tx_byte), 32'h41);
    repeat (4) nxt();

    // guard spacing with a never-busy transmitter
    lq.delete(); lt.delete();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i); nxt();
    end
    wr_en = 1'b0;
    repeat (15) nxt();
    check("guard_n", 32'(lq.size()), 32'h3);
    if (lt.size() == 3) begin
      check("guard_gap1", 32'(lt[1] - lt[0]), 32'h3);
      check("guard_gap2", 32'(lt[2] - lt[1]), 32'h3);
    end

    // burst with 10-cycle transmitter
    mode = 1; bcnt = 0; lq.delete(); lt.delete();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = hello[i]; nxt();
    end
    wr_en = 1'b0;
    n = 0;
    while (lq.size() < 5 && n < 200) begin nxt(); n++; end
    check("burst_n", 32'(lq.size()), 32'h5);
    for (int i = 0; i < 5; i++) begin
      if (i < lq.size()) check("burst_byte", 32'(lq[i]), 32'(hello[i]));
      if (i > 0 && i < lt.size()) check("burst_gap", 32'(lt[i] - lt[i-1]), 32'd12);
    end
    repeat (15) nxt();
    mode = 0; force_busy = 1'b0; bcnt = 0;
    nxt();

    // overflow with transmitter held busy
    force_busy = 1'b1; nxt();
    for (int i = 0; i <= DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i); nxt();
      if (i == DEPTH - 1) begin
        check("ovf_full", 32'(full), 32'h1);
        check("ovf_cnt", 32'(count), 32'(DEPTH));
        check("ovf_not_yet", 32'(overflow), 32'h0);
      end
    end
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_cnt_hold", 32'(count), 32'(DEPTH));
    wr_en = 1'b1; clr_overflow = 1'b1; wr_data = 8'hEE; nxt();
    check("ovf_setwins", 32'(overflow), 32'h1);
    wr_en = 1'b0; nxt();
    clr_overflow = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);
    force_busy = 1'b0; lq.delete();
    n = 0;
    while (lq.size() < DEPTH && n < 200) begin nxt(); n++; end
    check("ovf_drain_n", 32'(lq.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (i < lq.size()) check("ovf_drain_byte", 32'(lq[i]), 32'(8'h80 + 8'(i)));
    wait_empty(100, "ovf_drain_done");

    // write coinciding with a pop at count=DEPTH-1
    force_busy = 1'b1; nxt();
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i); nxt();
    end
    check("sim_pre_cnt", 32'(count), 32'(DEPTH - 1));
    force_busy = 1'b0; tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hB0; nxt();
    wr_en = 1'b0;
    check("sim_cnt", 32'(count), 32'(DEPTH - 1));
    check("sim_byte", 32'(tx_byte), 32'hA0);
    wait_empty(200, "sim_drain_done");

    // dropped write coinciding with a pop at full
    force_busy = 1'b1; nxt();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); nxt();
    end
    force_busy = 1'b0; tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hFF; nxt();
    wr_en = 1'b0;
    check("fullpop_cnt", 32'(count), 32'(DEPTH - 1));
    check("fullpop_ovf", 32'(overflow), 32'h1);
    check("fullpop_byte", 32'(tx_byte), 32'hC0);
    clr_overflow = 1'b1; nxt(); clr_overflow = 1'b0;
    wait_empty(200, "fullpop_drain_done");

    // randomized traffic
    mode = 2; sent = 0; n = 0;
    while (sent < 3 * DEPTH && n < 2000) begin
      wr_en = ($urandom_range(0, 99) < 60);
      wr_data = 8'($urandom);
      if (wr_en) sent++;
      nxt();
      n++;
    end
    check("rand_sent", 32'(sent), 32'(3 * DEPTH));
    mode = 0; force_busy = 1'b0;
    wait_empty(300, "rand_drain_done");

    // reset while tx_start is high
    wr_en = 1'b1; wr_data = 8'h11; nxt(); wr_en = 1'b0;
    nxt();
    check("rst_strobe_pre", 32'(tx_start), 32'h1);
    rst_n = 1'b0; nxt(); rst_n = 1'b1;
    check("rst_strobe_post", 32'(tx_start), 32'h0);
    check("rst_strobe_byte", 32'(tx_byte), 32'h0);
    repeat (2) nxt();

    // reset mid-drain
    mode = 1; bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + 8'(i); nxt();
    end
    wr_en = 1'b0;
    check("md_cnt5", 32'(count), 32'h5);
    rst_n = 1'b0; nxt(); rst_n = 1'b1;
    check("md_cnt0", 32'(count), 32'h0);
    check("md_empty", 32'(empty), 32'h1);
    check("md_start", 32'(tx_start), 32'h0);
    mode = 0; force_busy = 1'b0; tx_busy = 1'b0; bcnt = 0;
    wr_en = 1'b1; wr_data = 8'h5A; nxt(); wr_en = 1'b0;
    check("md_empty0", 32'(empty), 32'h0);
    check("md_start_early", 32'(tx_start), 32'h0);
    nxt();
    check("md_start", 32'(tx_start), 32'h1);
    check("md_byte", 32'(tx_byte), 32'h5A);
    repeat (3) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
